mr_if: RTL and testbench

//  Instruction fetch stage: generates sequential PCs, issues word fetches on the instruction-memory

---
 rtl/mr_pkg.sv | 17 +
 rtl/mr_if_fifo.sv | 52 +++++
 rtl/mr_if.sv | 131 +++++++++++++
 tb/tb_mr_if.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mr_pkg.sv
// Shared types and helpers for the mr instruction-fetch front end.
package mr_pkg;

    localparam int unsigned XLEN_W    = 32;
    localparam int unsigned IMAXLEN_W = 32;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [IMAXLEN_W-1:0] inst;
        logic [XLEN_W-1:0]    pc;
    } mr_if_entry_t;

    function automatic logic [XLEN_W-1:0] pc_step(input logic [XLEN_W-1:0] pc);
        return pc + XLEN_W'(4);
    endfunction

endpackage

// File: rtl/mr_if_fifo.sv
// Synchronous FIFO of fetch entries with push/pop and a flush that overrides both.
module mr_if_fifo
    import mr_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  mr_if_entry_t                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output mr_if_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    mr_if_entry_t   mem [DEPTH];
    logic [AW-1:0]  rptr;
    logic [AW-1:0]  wptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mr_if.sv
// Instruction fetch stage: sequential PC generation, imem request/response and decode handshake.
// Optional misaligned-redirect fault checking is enabled by defining MR_IF_MISALIGN_CHK_EN.
module mr_if
    import mr_pkg::*;
#(
    parameter logic [XLEN_W-1:0] RESET_PC   = XLEN_W'(0),
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [XLEN_W-1:0]     imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [IMAXLEN_W-1:0]  imem_resp_data,
    output logic [IMAXLEN_W-1:0]  inst,
    output logic [XLEN_W-1:0]     inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  br_valid,
    input  logic [XLEN_W-1:0]     br_target,
    output logic                  fetch_fault
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic              started;
    logic              fault;
    logic [XLEN_W-1:0] target;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW:0]       inflight;
    logic              accept;
    logic              resp_push;
    logic              inst_pop;
    mr_if_entry_t      resp_entry;
    mr_if_entry_t      head;

`ifdef MR_IF_MISALIGN_CHK_EN
    assign target = br_target;

    // Sticky until reset or a redirect to a word-aligned target.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else if (br_valid) begin
            fault <= (target[1:0] != 2'b00);
        end
    end
`else
    logic [1:0] unused_target_lsbs;

    assign unused_target_lsbs = br_target[1:0];
    assign target             = {br_target[XLEN_W-1:2], 2'b00};
    assign fault              = 1'b0;
`endif

    // Slots are reserved at issue time, so every accepted request has a home for its response.
    always_comb begin
        inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
        imem_req_valid = ~rst & started & ~br_valid & ~fault & (inflight < (CW+1)'(FIFO_DEPTH));
        imem_req_addr  = pc;
        accept         = imem_req_valid & imem_req_ready;
        resp_push      = imem_resp_valid & (discard == '0) & ~br_valid;
        resp_entry     = '{inst: imem_resp_data, pc: resp_pc};
        inst_valid     = ~rst & ~fifo_empty;
        inst           = head.inst;
        inst_pc        = head.pc;
        inst_pop       = inst_valid & inst_ready;
        fetch_fault    = ~rst & fault;
    end

    // A response in the redirect cycle belongs to the old stream and counts against discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            started     <= 1'b0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
            if (br_valid) begin
                pc      <= target;
                resp_pc <= target;
                discard <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (accept) begin
                    pc <= pc_step(pc);
                end
                if (imem_resp_valid) begin
                    if (discard != '0) begin
                        discard <= discard - CW'(1);
                    end else begin
                        resp_pc <= pc_step(resp_pc);
                    end
                end
            end
        end
    end

    mr_if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (resp_push),
        .push_data (resp_entry),
        .pop       (inst_pop),
        .flush     (br_valid),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_outstanding_bound: assert property (@(posedge clk) disable iff (rst)
        outstanding <= CW'(FIFO_DEPTH));
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        discard <= outstanding);
    a_no_push_overflow: assert property (@(posedge clk) disable iff (rst)
        !(resp_push && fifo_full && !inst_pop));

endmodule

// File: tb/tb_mr_if.sv
// Self-checking bench for mr_if: imem model with programmable latency, PC-stream scoreboard.
module tb_mr_if;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    typedef struct {
        logic [31:0] target;
        int          n;
        int          lat;
        bit          rnd_req;
        bit          rnd_inst;
        logic [31:0] exp_last;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        fetch_fault;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    vec_t        vecs[5];

    slot_t       slots[3];
    int          lat = 1;
    bit          rnd_req = 1'b0;
    bit          hold = 1'b0;
    int          acc_cnt = 0;

    mr_if dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    // In-order memory: a request accepted at an edge is presented lat-1 edges later.
    always @(posedge clk) begin
        logic        acc;
        logic [31:0] a;
        logic        r;
        int          l;
        bit          rr;
        bit          h;
        acc = !rst && imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        r   = rst;
        l   = lat;
        rr  = rnd_req;
        h   = hold;
        if (acc) acc_cnt++;
        #1;
        if (r) begin
            for (int i = 0; i < 3; i++) slots[i] = '0;
        end else begin
            slots[0] = slots[1];
            slots[1] = slots[2];
            slots[2] = '0;
            if (acc) slots[l-1] = {1'b1, a};
        end
        imem_resp_valid = slots[0].v;
        imem_resp_data  = slots[0].a ^ KEY;
        imem_req_ready  = h ? 1'b0 : (rr ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] t);
        br_valid  = 1'b1;
        br_target = t;
        exp_q.delete();
        step();
        br_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] start, input int n);
        logic [31:0] p;
        p = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    // Wait for the queued expected instructions to be delivered, comparing each handshake.
    task automatic run_stream(input int n, input bit rnd, output logic [31:0] last);
        int          got;
        int          guard;
        logic [31:0] e;
        got   = 0;
        guard = 0;
        last  = '0;
        while (got < n && guard < 400) begin
            @(negedge clk);
            if (inst_valid && inst_ready && !br_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst actual=%h expected=none", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e);
                    chk("inst", inst, e ^ KEY);
                end
                last = inst_pc;
                got++;
            end
            step();
            inst_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            guard++;
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout actual=%0d expected=%0d", got, n);
        end
    endtask

    // Stall issue until the memory pipeline drains, then change its latency.
    task automatic set_lat(input int l);
        inst_ready = 1'b0;
        hold       = 1'b1;
        repeat (5) step();
        lat  = l;
        hold = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [31:0] last;

        vecs[0] = '{target: 32'h0000_1000, n: 6, lat: 1, rnd_req: 1'b0, rnd_inst: 1'b0, exp_last: 32'h0000_1014};
        vecs[1] = '{target: 32'h0000_2000, n: 8, lat: 3, rnd_req: 1'b1, rnd_inst: 1'b0, exp_last: 32'h0000_201C};
        vecs[2] = '{target: 32'hFFFF_FFF8, n: 4, lat: 1, rnd_req: 1'b0, rnd_inst: 1'b0, exp_last: 32'h0000_0004};
        vecs[3] = '{target: 32'h0000_0040, n: 6, lat: 2, rnd_req: 1'b0, rnd_inst: 1'b1, exp_last: 32'h0000_0054};
        vecs[4] = '{target: 32'h0000_8000, n: 5, lat: 3, rnd_req: 1'b1, rnd_inst: 1'b1, exp_last: 32'h0000_8010};

        // Reset values, then first fetch from RESET_PC with minimum latency.
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_inst_valid", 32'(inst_valid), 32'd0);
            chk("rst_fault", 32'(fetch_fault), 32'd0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("post_rst_inst_valid", 32'(inst_valid), 32'd0);
        step();
        @(negedge clk);
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0000_0000);
        step();
        @(negedge clk);
        chk("latency_n1_inst_valid", 32'(inst_valid), 32'd0);
        step();
        @(negedge clk);
        chk("latency_n2_inst_valid", 32'(inst_valid), 32'd1);
        chk("latency_n2_inst_pc", inst_pc, 32'h0000_0000);
        step();
        push_exp(32'h0, 8);
        inst_ready = 1'b1;
        run_stream(8, 1'b0, last);
        chk("seq_last", last, 32'h0000_001C);

        // Decode stalled: only FIFO_DEPTH requests may be issued, nothing lost.
        inst_ready = 1'b0;
        acc_cnt    = 0;
        redirect(32'h0000_0300);
        repeat (10) step();
        chk("stall_accepts", 32'(acc_cnt), 32'd2);
        @(negedge clk);
        chk("stall_inst_valid", 32'(inst_valid), 32'd1);
        chk("stall_head_pc", inst_pc, 32'h0000_0300);
        step();
        push_exp(32'h0000_0300, 6);
        inst_ready = 1'b1;
        run_stream(6, 1'b0, last);
        chk("stall_last", last, 32'h0000_0314);

        // Redirect with two outstanding, one of them responding in the redirect cycle.
        set_lat(2);
        redirect(32'h0000_0500);
        @(negedge clk);
        chk("flush_req1", 32'(imem_req_valid), 32'd1);
        step();
        @(negedge clk);
        chk("flush_req2", 32'(imem_req_valid), 32'd1);
        step();
        br_valid  = 1'b1;
        br_target = 32'h0000_0100;
        exp_q.delete();
        @(negedge clk);
        chk("flush_resp_same_cycle", 32'(imem_resp_valid), 32'd1);
        chk("flush_no_req", 32'(imem_req_valid), 32'd0);
        step();
        br_valid = 1'b0;
        push_exp(32'h0000_0100, 4);
        inst_ready = 1'b1;
        run_stream(4, 1'b0, last);
        chk("flush_last", last, 32'h0000_010C);

        // Table: latency, random memory ready, random decode ready, PC wrap.
        foreach (vecs[i]) begin
            set_lat(vecs[i].lat);
            rnd_req = vecs[i].rnd_req;
            redirect(vecs[i].target);
            push_exp(vecs[i].target, vecs[i].n);
            inst_ready = 1'b1;
            run_stream(vecs[i].n, vecs[i].rnd_inst, last);
            chk("vec_last", last, vecs[i].exp_last);
            rnd_req = 1'b0;
        end

        // Misaligned redirect target.
        set_lat(1);
        redirect(32'h0000_0102);
`ifdef MR_IF_MISALIGN_CHK_EN
        @(negedge clk);
        chk("fault_set", 32'(fetch_fault), 32'd1);
        step();
        repeat (4) begin
            @(negedge clk);
            chk("fault_no_req", 32'(imem_req_valid), 32'd0);
            chk("fault_no_inst", 32'(inst_valid), 32'd0);
            step();
        end
        redirect(32'h0000_0200);
        @(negedge clk);
        chk("fault_cleared", 32'(fetch_fault), 32'd0);
        step();
        push_exp(32'h0000_0200, 4);
        inst_ready = 1'b1;
        run_stream(4, 1'b0, last);
        chk("fault_restart_last", last, 32'h0000_020C);
`else
        @(negedge clk);
        chk("fault_tied_low", 32'(fetch_fault), 32'd0);
        step();
        push_exp(32'h0000_0100, 4);
        inst_ready = 1'b1;
        run_stream(4, 1'b0, last);
        chk("align_forced_last", last, 32'h0000_010C);
`endif

        // Reset in the middle of streaming.
        inst_ready = 1'b1;
        redirect(32'h0000_0700);
        repeat (3) step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_fault", 32'(fetch_fault), 32'd0);
        step();
        @(negedge clk);
        chk("midrst_req_valid2", 32'(imem_req_valid), 32'd0);
        chk("midrst_inst_valid2", 32'(inst_valid), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_req", 32'(imem_req_valid), 32'd0);
        chk("midrst_after_inst", 32'(inst_valid), 32'd0);
        step();
        exp_q.delete();
        push_exp(32'h0, 4);
        run_stream(4, 1'b0, last);
        chk("midrst_last", last, 32'h0000_000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
